// File: rtl/line_deinterleave_fetch.sv
// line_deinterleave_fetch
// Fetches one image line from frame RAM (1-cycle read latency). Even-indexed
// pixels go to one buffer and odd-indexed pixels to another. The line is then
// streamed as LINE_LEN/2 even/odd pairs. The block waits for the downstream
// line_done ack before it fetches the next line, until the frame is complete.
// Optional build macro: LEVEL_SHIFT_EN. When it is defined, each sample is
// pixel - 2^(PIX_W-1), sign-extended to 16 bits. When it is undefined, each
// sample is the pixel zero-extended to 16 bits.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | issuing LINE_LEN consecutive RAM reads for the current line
// DRAIN    | one cycle to capture the last returned pixel
// STREAM   | presenting LINE_LEN/2 even/odd pairs, one per cycle
// WAIT_ACK | holding until downstream acknowledges the line
// DONE     | one-cycle frame_done pulse, then back to IDLE

module line_deinterleave_fetch #(
    parameter int LINE_LEN  = 64,
    parameter int NUM_LINES = 64,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              line_done,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_rd_addr,
    input  logic [PIX_W-1:0]  pix_rd_data,
    output logic              data_valid,
    output logic [15:0]       data_out_even,
    output logic [15:0]       data_out_odd,
    output logic [7:0]        line_address,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int PW = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(LINE_LEN - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(LINE_LEN / 2 - 1);
    localparam logic [7:0]    LINE_LAST = 8'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DRAIN, STREAM, WAIT_ACK, DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    col;
    logic [7:0]       line;
    logic [PW-1:0]    pair;
    logic             rd_en_q;
    logic [CW-1:0]    col_q;
    logic [PIX_W-1:0] even_buf [LINE_LEN/2];
    logic [PIX_W-1:0] odd_buf  [LINE_LEN/2];

    function automatic logic [15:0] to_sample(input logic [PIX_W-1:0] p);
`ifdef LEVEL_SHIFT_EN
        logic [PIX_W-1:0] s;
        // Subtracting 2^(PIX_W-1) modulo 2^PIX_W is the same as flipping the MSB.
        s = p ^ (PIX_W'(1) << (PIX_W - 1));
        return {{(16 - PIX_W){s[PIX_W-1]}}, s};
`else
        return {{(16 - PIX_W){1'b0}}, p};
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and the outputs decoded from the state.
    always_comb begin
        state_d     = state_q;
        pix_rd_en   = 1'b0;
        pix_rd_addr = '0;
        busy        = (state_q != IDLE);
        frame_done  = 1'b0;
        case (state_q)
            IDLE:     if (start) state_d = FETCH;
            FETCH: begin
                pix_rd_en   = 1'b1;
                pix_rd_addr = ADDR_W'(line) * ADDR_W'(LINE_LEN) + ADDR_W'(col);
                if (col == COL_LAST) state_d = DRAIN;
            end
            DRAIN:    state_d = STREAM;
            STREAM:   if (pair == PAIR_LAST) state_d = WAIT_ACK;
            WAIT_ACK: if (line_done) state_d = (line == LINE_LAST) ? DONE : FETCH;
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Counters, the read-return pipeline, and the registered pair outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            line          <= '0;
            pair          <= '0;
            rd_en_q       <= 1'b0;
            col_q         <= '0;
            data_valid    <= 1'b0;
            data_out_even <= '0;
            data_out_odd  <= '0;
        end else begin
            rd_en_q    <= pix_rd_en;
            col_q      <= col;
            data_valid <= (state_q == STREAM);
            case (state_q)
                IDLE: if (start) begin
                    line <= '0;
                    col  <= '0;
                end
                FETCH:    col  <= (col == COL_LAST) ? '0 : col + 1'b1;
                STREAM:   pair <= (pair == PAIR_LAST) ? '0 : pair + 1'b1;
                WAIT_ACK: if (line_done && line != LINE_LAST) line <= line + 8'd1;
                default:  ;
            endcase
            if (state_q == STREAM) begin
                data_out_even <= to_sample(even_buf[pair]);
                data_out_odd  <= to_sample(odd_buf[pair]);
            end
        end
    end

    // Deinterleave the returning pixels; the buffers hold data only, so they have no reset.
    always_ff @(posedge clk) begin
        if (rd_en_q) begin
            if (col_q[0]) odd_buf[PW'(col_q >> 1)]  <= pix_rd_data;
            else          even_buf[PW'(col_q >> 1)] <= pix_rd_data;
        end
    end

    assign line_address = line;

endmodule

// File: tb/tb_line_deinterleave_fetch.sv
// Directed testbench for line_deinterleave_fetch with its default parameters.
// A frame-RAM model with 1-cycle read latency is preloaded with pixel = addr & 8'hFF.

module tb_line_deinterleave_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        line_done;
    logic        pix_rd_en;
    logic [13:0] pix_rd_addr;
    logic [7:0]  pix_rd_data;
    logic        data_valid;
    logic [15:0] data_out_even;
    logic [15:0] data_out_odd;
    logic [7:0]  line_address;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_pulses = 0;

    logic [7:0]  mem [0:16383];
    logic [15:0] ge [0:63];
    logic [15:0] go [0:63];
    logic [7:0]  gl [0:63];

    line_deinterleave_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line_done(line_done),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .data_valid(data_valid), .data_out_even(data_out_even), .data_out_odd(data_out_odd),
        .line_address(line_address), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Frame RAM model: 1-cycle read latency.
    always @(posedge clk) if (pix_rd_en) pix_rd_data <= mem[pix_rd_addr];

    // Count frame_done pulses.
    always @(negedge clk) if (frame_done === 1'b1) fd_pulses++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_pix(input int v);
        int p;
        p = v & 255;
`ifdef LEVEL_SHIFT_EN
        return 16'(p - 128);
`else
        return 16'(p);
`endif
    endfunction

    task automatic start_frame();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic ack_line(input int delay);
        repeat (delay) @(negedge clk);
        line_done = 1'b1;
        @(negedge clk) line_done = 1'b0;
    endtask

    task automatic scan_fetch(input int ln, output int nerr);
        nerr = 0;
        for (int c = 0; c < 64; c++) begin
            if (pix_rd_en !== 1'b1 || pix_rd_addr !== 14'(ln * 64 + c)) nerr++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        while (data_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ok = (data_valid === 1'b1);
    endtask

    task automatic collect(input int inj, output int n);
        n = 0;
        while (data_valid === 1'b1 && n < 64) begin
            ge[n] = data_out_even;
            go[n] = data_out_odd;
            gl[n] = line_address;
            if (n == inj) begin
                line_done = 1'b1;
                start     = 1'b1;
            end else begin
                line_done = 1'b0;
                start     = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        line_done = 1'b0;
        start     = 1'b0;
    endtask

    task automatic score(input int ln, input int n, output int nerr);
        nerr = 0;
        for (int k = 0; k < n; k++) begin
            if (ge[k] !== exp_pix(ln * 64 + 2 * k)) nerr++;
            if (go[k] !== exp_pix(ln * 64 + 2 * k + 1)) nerr++;
            if (gl[k] !== 8'(ln)) nerr++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; line_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_rd_en, pix_rd_addr, data_valid, data_out_even, data_out_odd,
             line_address, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%0d v=%b e=%h o=%h la=%0d busy=%b fd=%b expected all 0",
                     pix_rd_en, pix_rd_addr, data_valid, data_out_even, data_out_odd,
                     line_address, busy, frame_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_line();
        int nerr, cyc, n;
        bit ok;
        start_frame();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_fetch got %b expected 1", busy); end
        scan_fetch(0, nerr);
        checks++;
        if (nerr != 0) begin errors++; $display("FAIL fetch_line0 got %0d bad cycles expected 0", nerr); end
        checks++;
        if (pix_rd_en !== 1'b0) begin errors++; $display("FAIL drain_rd_en got %b expected 0", pix_rd_en); end
        wait_valid(cyc, ok);
        checks++;
        if (!ok || cyc + 64 != 66) begin
            errors++;
            $display("FAIL first_latency got %0d expected 66", cyc + 64);
        end
        collect(-1, n);
        checks++;
        if (n != 32) begin errors++; $display("FAIL pairs_line0 got %0d expected 32", n); end
        score(0, n, nerr);
        checks++;
        if (nerr != 0) begin errors++; $display("FAIL data_line0 got %0d bad fields expected 0", nerr); end
        checks++;
        if (ge[0] !== exp_pix(0) || go[31] !== exp_pix(63)) begin
            errors++;
            $display("FAIL line0_ends got even0=%h odd31=%h expected %h %h", ge[0], go[31], exp_pix(0), exp_pix(63));
        end
    endtask

    task automatic test_second_line();
        int nerr, cyc, n, bad;
        bit ok;
        ack_line(5);
        checks++;
        if (line_address !== 8'd1 || pix_rd_addr !== 14'd64) begin
            errors++;
            $display("FAIL line1_start got la=%0d addr=%0d expected 1 64", line_address, pix_rd_addr);
        end
        scan_fetch(1, nerr);
        checks++;
        if (nerr != 0) begin errors++; $display("FAIL fetch_line1 got %0d bad cycles expected 0", nerr); end
        wait_valid(cyc, ok);
        collect(5, n);
        checks++;
        if (!ok || n != 32) begin errors++; $display("FAIL pairs_line1_ignored got %0d expected 32", n); end
        score(1, n, nerr);
        checks++;
        if (nerr != 0 || ge[0] !== exp_pix(64) || go[0] !== exp_pix(65)) begin
            errors++;
            $display("FAIL data_line1 got %0d bad fields even0=%h odd0=%h expected 0 %h %h",
                     nerr, ge[0], go[0], exp_pix(64), exp_pix(65));
        end
        bad = 0;
        repeat (8) begin
            if (pix_rd_en !== 1'b0 || busy !== 1'b1 || data_valid !== 1'b0 || line_address !== 8'd1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wait_ack_hold got %0d bad cycles expected 0", bad); end
        ack_line(0);
        checks++;
        if (line_address !== 8'd2 || pix_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL line2_start got la=%0d en=%b expected 2 1", line_address, pix_rd_en);
        end
    endtask

    task automatic test_reset_mid();
        int nerr, cyc, n, bad;
        bit ok;
        scan_fetch(2, nerr);
        wait_valid(cyc, ok);
        collect(-1, n);
        ack_line(1);
        scan_fetch(3, nerr);
        wait_valid(cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL line3_valid got timeout expected valid"); end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || pix_rd_en !== 1'b0 || busy !== 1'b0 || line_address !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid got v=%b en=%b busy=%b la=%0d expected 0 0 0 0",
                     data_valid, pix_rd_en, busy, line_address);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_valid !== 1'b0 || pix_rd_en !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (data_valid !== 1'b0 || pix_rd_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL after_reset_quiet got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_full_frame();
        int nerr, cyc, n, fetch_bad, data_bad, total, fd_base;
        bit ok;
        fetch_bad = 0; data_bad = 0; total = 0;
        fd_base = fd_pulses;
        start_frame();
        checks++;
        if (pix_rd_addr !== 14'd0 || line_address !== 8'd0) begin
            errors++;
            $display("FAIL restart_line0 got addr=%0d la=%0d expected 0 0", pix_rd_addr, line_address);
        end
        for (int ln = 0; ln < 64; ln++) begin
            scan_fetch(ln, nerr);
            fetch_bad += nerr;
            wait_valid(cyc, ok);
            if (!ok) data_bad++;
            collect(-1, n);
            total += n;
            score(ln, n, nerr);
            data_bad += nerr;
            if (ln < 63) ack_line(1);
        end
        checks++;
        if (fd_pulses != fd_base) begin
            errors++;
            $display("FAIL early_frame_done got %0d pulses expected 0", fd_pulses - fd_base);
        end
        ack_line(1);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_pulse got fd=%b busy=%b expected 1 1", frame_done, busy);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_end got fd=%b busy=%b expected 0 0", frame_done, busy);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (fd_pulses - fd_base != 1) begin
            errors++;
            $display("FAIL frame_done_count got %0d expected 1", fd_pulses - fd_base);
        end
        checks++;
        if (fetch_bad != 0) begin errors++; $display("FAIL frame_fetch got %0d bad cycles expected 0", fetch_bad); end
        checks++;
        if (total != 2048) begin errors++; $display("FAIL frame_pairs got %0d expected 2048", total); end
        checks++;
        if (data_bad != 0) begin errors++; $display("FAIL frame_data got %0d bad fields expected 0", data_bad); end
    endtask

    task automatic test_level_shift();
        int cyc;
        bit ok;
        logic [15:0] exp_e, exp_o;
`ifdef LEVEL_SHIFT_EN
        exp_e = 16'hFF80; exp_o = 16'h007F;
`else
        exp_e = 16'h0000; exp_o = 16'h00FF;
`endif
        mem[0] = 8'd0;
        mem[1] = 8'd255;
        start_frame();
        wait_valid(cyc, ok);
        checks++;
        if (!ok || data_out_even !== exp_e || data_out_odd !== exp_o) begin
            errors++;
            $display("FAIL level_shift got even=%h odd=%h expected %h %h", data_out_even, data_out_odd, exp_e, exp_o);
        end
        mem[1] = 8'd1;
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 8'(a & 255);
        test_reset();
        test_first_line();
        test_second_line();
        test_reset_mid();
        test_full_frame();
        test_level_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
